// File: rtl/dw_window_router.sv
// Depthwise window router: stores the last KSIZE feature-map rows in a ring and
// streams KSIZE x SPAN pixel patches, one beat per POX output columns.
module dw_window_router #(
  parameter int DW     = 32,
  parameter int BUFW   = 32,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int POX    = 16,
  parameter int RCW    = 8,
  localparam int SPAN  = (POX - 1) * STRIDE + KSIZE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_pad,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_sof,
  input  logic                                   in_eof,
  input  logic [BUFW-1:0][DW-1:0]                in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [KSIZE-1:0][SPAN-1:0][DW-1:0]     out_data,
  output logic [POX-1:0]                         out_mask,
  output logic [7:0]                             out_beat,
  output logic                                   out_last,
  output logic                                   out_eof,
  output logic                                   dbg_state
);

  // Handshake: a transfer happens on a clock edge where valid & ready are both
  // high; out_* hold stable while out_valid & !out_ready, and in_ready never
  // depends combinationally on in_valid.

  localparam int   KW      = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int   XW      = $clog2(BUFW);
  localparam int   PADL_P  = (KSIZE - 1) / 2;
  localparam int   OUTW_N  = (BUFW - KSIZE) / STRIDE + 1;
  localparam int   OUTW_P  = (BUFW + STRIDE - 1) / STRIDE;
  localparam int   NBEAT_N = (OUTW_N + POX - 1) / POX;
  localparam int   NBEAT_P = (OUTW_P + POX - 1) / POX;
  localparam logic KPAR    = 1'(KSIZE % 2);

  typedef enum logic {S_FILL = 1'b0, S_EMIT = 1'b1} state_t;

  state_t                                state_q, state_d;
  logic [RCW-1:0]                        cnt_q, cnt_d;
  logic [KW-1:0]                         wp_q, wp_d;
  logic                                  pad_q, pad_d;
  logic                                  closed_q, closed_d;
  logic                                  eof_win_q, eof_win_d;
  logic [KSIZE-1:0][BUFW-1:0][DW-1:0]    ring_q, ring_d;
  logic [7:0]                            beat_q, beat_d;
  logic                                  out_valid_q, out_valid_d;
  logic [KSIZE-1:0][SPAN-1:0][DW-1:0]    out_data_q, out_data_d;
  logic [POX-1:0]                        out_mask_q, out_mask_d;
  logic                                  out_last_q, out_last_d;
  logic                                  out_eof_q, out_eof_d;

  logic [7:0]                            load_beat;
  logic [KSIZE-1:0][SPAN-1:0][DW-1:0]    load_data;
  logic [POX-1:0]                        load_mask;
  logic                                  load_last;
  logic [RCW-1:0]                        cnt_new;
  logic                                  store;
  logic                                  trig;

  // Patch for the beat about to be presented; oldest ring row sits at wp_q.
  always_comb begin
    int padl;
    int outw;
    int nbeat;
    int x;
    int slot;
    padl      = pad_q ? PADL_P : 0;
    outw      = pad_q ? OUTW_P : OUTW_N;
    nbeat     = pad_q ? NBEAT_P : NBEAT_N;
    x         = 0;
    slot      = 0;
    load_beat = out_valid_q ? beat_q + 8'd1 : 8'd0;
    load_data = '0;
    load_mask = '0;
    for (int ky = 0; ky < KSIZE; ky++) begin
      slot = (int'(wp_q) + ky) % KSIZE;
      for (int j = 0; j < SPAN; j++) begin
        x = int'(load_beat) * POX * STRIDE - padl + j;
        if (x >= 0 && x < BUFW) load_data[ky][j] = ring_q[KW'(slot)][XW'(x)];
      end
    end
    for (int p = 0; p < POX; p++) load_mask[p] = (int'(load_beat) * POX + p) < outw;
    load_last = (int'(load_beat) == nbeat - 1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wp_d        = wp_q;
    pad_d       = pad_q;
    closed_d    = closed_q;
    eof_win_d   = eof_win_q;
    ring_d      = ring_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    out_eof_d   = out_eof_q;
    cnt_new     = in_sof ? RCW'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + RCW'(1));
    // Rows arriving after eof are swallowed until the next sof.
    store       = (state_q == S_FILL) && in_valid && (in_sof || !closed_q);
    trig        = (cnt_new >= RCW'(KSIZE)) && ((STRIDE == 1) || (cnt_new[0] == KPAR));
    case (state_q)
      S_FILL: begin
        if (store) begin
          ring_d[wp_q] = in_data;
          wp_d         = (wp_q == KW'(KSIZE - 1)) ? '0 : wp_q + KW'(1);
          cnt_d        = cnt_new;
          closed_d     = in_eof;
          if (in_sof) pad_d = cfg_pad;
          if (trig) begin
            state_d   = S_EMIT;
            eof_win_d = in_eof;
          end
        end
      end
      S_EMIT: begin
        if (!out_valid_q || out_ready) begin
          if (out_valid_q && out_last_q) begin
            state_d     = S_FILL;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_eof_d   = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            beat_d      = load_beat;
            out_data_d  = load_data;
            out_mask_d  = load_mask;
            out_last_d  = load_last;
            out_eof_d   = load_last & eof_win_q;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      wp_q        <= '0;
      pad_q       <= 1'b0;
      closed_q    <= 1'b0;
      eof_win_q   <= 1'b0;
      ring_q      <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wp_q        <= wp_d;
      pad_q       <= pad_d;
      closed_q    <= closed_d;
      eof_win_q   <= eof_win_d;
      ring_q      <= ring_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_beat  = beat_q;
  assign out_last  = out_last_q;
  assign out_eof   = out_eof_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dw_window_router.sv
// Bench for dw_window_router: a stride-1 and a stride-2 instance share the input
// bus; a row-history model predicts every beat into an expected queue.
module tb_dw_window_router;

  localparam int DW    = 32;
  localparam int B     = 32;
  localparam int K     = 3;
  localparam int POX   = 16;
  localparam int SPAN1 = (POX - 1) * 1 + K;
  localparam int SPAN2 = (POX - 1) * 2 + K;
  localparam int EW    = 43;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cfg_pad, in_valid, in_sof, in_eof, out_ready, sel;
  logic [B-1:0][DW-1:0] in_data;

  logic iv1, iv2, or1, or2, ir1, ir2, ov1, ov2, ol1, ol2, oe1, oe2, ds1, ds2;
  logic [K-1:0][SPAN1-1:0][DW-1:0] od1;
  logic [K-1:0][SPAN2-1:0][DW-1:0] od2;
  logic [POX-1:0] om1, om2;
  logic [7:0] ob1, ob2;

  assign iv1 = in_valid & ~sel;
  assign iv2 = in_valid & sel;
  assign or1 = out_ready & ~sel;
  assign or2 = out_ready & sel;

  dw_window_router #(.DW(DW), .BUFW(B), .KSIZE(K), .STRIDE(1), .POX(POX), .RCW(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .cfg_pad(cfg_pad), .in_valid(iv1), .in_ready(ir1),
    .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_mask(om1), .out_beat(ob1), .out_last(ol1), .out_eof(oe1),
    .dbg_state(ds1));

  dw_window_router #(.DW(DW), .BUFW(B), .KSIZE(K), .STRIDE(2), .POX(POX), .RCW(8)) u_s2 (
    .clk(clk), .rst_n(rst_n), .cfg_pad(cfg_pad), .in_valid(iv2), .in_ready(ir2),
    .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data), .out_valid(ov2), .out_ready(or2),
    .out_data(od2), .out_mask(om2), .out_beat(ob2), .out_last(ol2), .out_eof(oe2),
    .dbg_state(ds2));

  logic cur_valid, cur_in_ready, cur_last, cur_eof;
  logic [POX-1:0] cur_mask;
  logic [7:0] cur_beat;
  assign cur_valid    = sel ? ov2 : ov1;
  assign cur_in_ready = sel ? ir2 : ir1;
  assign cur_last     = sel ? ol2 : ol1;
  assign cur_eof      = sel ? oe2 : oe1;
  assign cur_mask     = sel ? om2 : om1;
  assign cur_beat     = sel ? ob2 : ob1;

  // Reference model state: every stored row of every frame, in arrival order.
  logic [DW-1:0] hist [0:511][0:B-1];
  int hn, fr_cnt;
  bit m_closed, m_pad;
  logic [EW-1:0] exp_q[$];
  int n_checks, n_fail;

  function automatic logic [DW-1:0] get_pix(input int ky, input int j);
    return sel ? od2[ky][j] : od1[ky][j];
  endfunction

  function automatic int cur_s();
    return sel ? 2 : 1;
  endfunction

  task automatic model_row(input bit sof, input bit eof, input bit pad_in);
    bit stored;
    int ow, nb;
    logic [15:0] m;
    logic lst;
    stored = 0;
    if (sof) begin
      fr_cnt = 1; m_pad = pad_in; stored = 1;
    end else if (!m_closed) begin
      fr_cnt++; stored = 1;
    end
    if (stored) begin
      for (int c = 0; c < B; c++) hist[hn][c] = in_data[c];
      hn++;
      m_closed = eof;
      if (fr_cnt >= K && ((fr_cnt - K) % cur_s()) == 0) begin
        ow = m_pad ? (B + cur_s() - 1) / cur_s() : (B - K) / cur_s() + 1;
        nb = (ow + POX - 1) / POX;
        for (int b = 0; b < nb; b++) begin
          m = '0;
          for (int p = 0; p < POX; p++) if (b * POX + p < ow) m[p] = 1'b1;
          lst = (b == nb - 1);
          exp_q.push_back({m_pad, lst & eof, lst, 8'(b), m, 16'(hn - K)});
        end
      end
    end
  endtask

  task automatic set_row_pat(input int r);
    for (int c = 0; c < B; c++) in_data[c] = DW'(r * 100 + c);
  endtask

  task automatic set_row_rand();
    for (int c = 0; c < B; c++) in_data[c] = $urandom;
  endtask

  task automatic send_row(input bit sof, input bit eof);
    int t;
    in_sof = sof; in_eof = eof; in_valid = 1'b1; t = 0;
    while (!cur_in_ready && t < 200) begin @(negedge clk); t++; end
    n_checks++;
    if (!cur_in_ready) begin
      n_fail++;
      $display("FAIL send_row_timeout in_ready=%0b expected 1", cur_in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_row(sof, eof, cfg_pad);
      @(negedge clk);
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!cur_valid && t < 50) begin @(negedge clk); t++; end
    n_checks++;
    if (!cur_valid) begin
      n_fail++;
      $display("FAIL wait_valid_timeout out_valid=%0b expected 1", cur_valid);
    end
  endtask

  // Scoreboard: each transferred beat is popped from exp_q and checked.
  task automatic take_beats(input int n, input bit rnd);
    int got, t, x, span, bad_ky, bad_j;
    bit bad;
    logic [EW-1:0] d;
    logic [DW-1:0] ev, av, bad_a, bad_e;
    got = 0; t = 0;
    span = sel ? SPAN2 : SPAN1;
    while (got < n && t < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cur_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat got beat %0d expected none", cur_beat);
        end else begin
          d = exp_q.pop_front();
          if (cur_beat !== d[39:32]) begin
            n_fail++; $display("FAIL beat_idx got %0d exp %0d", cur_beat, d[39:32]);
          end
          n_checks++;
          if (cur_mask !== d[31:16]) begin
            n_fail++; $display("FAIL beat_mask got %h exp %h", cur_mask, d[31:16]);
          end
          n_checks++;
          if (cur_last !== d[40]) begin
            n_fail++; $display("FAIL beat_last got %0b exp %0b", cur_last, d[40]);
          end
          n_checks++;
          if (cur_eof !== d[41]) begin
            n_fail++; $display("FAIL beat_eof got %0b exp %0b", cur_eof, d[41]);
          end
          bad = 0; bad_ky = 0; bad_j = 0; bad_a = '0; bad_e = '0;
          for (int ky = 0; ky < K; ky++) begin
            for (int j = 0; j < span; j++) begin
              x = int'(d[39:32]) * POX * cur_s() - (d[42] ? 1 : 0) + j;
              ev = (x < 0 || x >= B) ? '0 : hist[int'(d[15:0]) + ky][x];
              av = get_pix(ky, j);
              if (av !== ev && !bad) begin
                bad = 1; bad_ky = ky; bad_j = j; bad_a = av; bad_e = ev;
              end
            end
          end
          n_checks++;
          if (bad) begin
            n_fail++;
            $display("FAIL beat_data [%0d][%0d] got %h exp %h", bad_ky, bad_j, bad_a, bad_e);
          end
        end
        got++;
      end
      @(negedge clk); t++;
    end
    out_ready = 1'b0;
    if (n > 0) begin
      n_checks++;
      if (got < n) begin
        n_fail++; $display("FAIL take_beats_timeout got %0d beats exp %0d", got, n);
      end
    end
  endtask

  task automatic check_idle();
    bit seen;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (cur_valid) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL idle_valid got out_valid=1 exp 0"); end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL idle_pending got %0d beats outstanding exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got %0b%0b exp 00", ov1, ov2);
    end
    n_checks++;
    if (ir1 !== 1'b1 || ir2 !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready got %0b%0b exp 11", ir1, ir2);
    end
    n_checks++;
    if (od1 !== '0 || od2 !== '0 || om1 !== '0 || om2 !== '0) begin
      n_fail++; $display("FAIL rst_data_mask got nonzero exp 0");
    end
    n_checks++;
    if ({ob1, ob2, ol1, ol2, oe1, oe2} !== '0) begin
      n_fail++; $display("FAIL rst_beat_flags got %h exp 0", {ob1, ob2, ol1, ol2, oe1, oe2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 0; cfg_pad = 0;
    set_row_pat(0); send_row(1, 0);
    set_row_pat(1); send_row(0, 0);
    set_row_pat(2); send_row(0, 0);
    n_checks++;
    if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL latency_c1 got %0b exp 0", cur_valid); end
    @(negedge clk);
    n_checks++;
    if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL latency_c2 got %0b exp 1", cur_valid); end
    n_checks++;
    if (get_pix(0, 0) !== 32'd0) begin n_fail++; $display("FAIL w1b0_d00 got %0d exp 0", get_pix(0, 0)); end
    n_checks++;
    if (get_pix(2, 17) !== 32'd217) begin n_fail++; $display("FAIL w1b0_d217 got %0d exp 217", get_pix(2, 17)); end
    n_checks++;
    if (cur_mask !== 16'hFFFF) begin n_fail++; $display("FAIL w1b0_mask got %h exp ffff", cur_mask); end
    take_beats(1, 0);
    wait_valid();
    n_checks++;
    if (cur_mask !== 16'h3FFF) begin n_fail++; $display("FAIL w1b1_mask got %h exp 3fff", cur_mask); end
    take_beats(1, 0);
    set_row_pat(3); send_row(0, 1);
    wait_valid();
    take_beats(1, 0);
    wait_valid();
    n_checks++;
    if (cur_eof !== 1'b1) begin n_fail++; $display("FAIL w2b1_eof got %0b exp 1", cur_eof); end
    take_beats(1, 0);
    check_idle();
  endtask

  task automatic test_pad();
    bit ok;
    sel = 0; cfg_pad = 1;
    set_row_pat(0); send_row(1, 0);
    cfg_pad = 0;
    set_row_pat(1); send_row(0, 0);
    set_row_pat(2); send_row(0, 0);
    wait_valid();
    ok = 1;
    for (int ky = 0; ky < K; ky++) if (get_pix(ky, 0) !== '0) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pad_left got %h exp 0", get_pix(0, 0)); end
    n_checks++;
    if (get_pix(0, 1) !== '0) begin n_fail++; $display("FAIL pad_d01 got %0d exp 0", get_pix(0, 1)); end
    n_checks++;
    if (cur_mask !== 16'hFFFF) begin n_fail++; $display("FAIL pad_b0_mask got %h exp ffff", cur_mask); end
    take_beats(1, 0);
    wait_valid();
    ok = 1;
    for (int ky = 0; ky < K; ky++) if (get_pix(ky, 17) !== '0) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pad_right got %h exp 0", get_pix(2, 17)); end
    n_checks++;
    if (cur_mask !== 16'hFFFF) begin n_fail++; $display("FAIL pad_b1_mask got %h exp ffff", cur_mask); end
    take_beats(1, 0);
    set_row_pat(3); send_row(0, 1);
    take_beats(2, 0);
    check_idle();
  endtask

  task automatic test_stride2();
    sel = 1; cfg_pad = 1;
    set_row_pat(0); send_row(1, 0);
    set_row_pat(1); send_row(0, 0);
    set_row_pat(2); send_row(0, 0);
    wait_valid();
    n_checks++;
    if (get_pix(0, 2) !== 32'd1) begin n_fail++; $display("FAIL s2_d02 got %0d exp 1", get_pix(0, 2)); end
    n_checks++;
    if (cur_mask !== 16'hFFFF || cur_last !== 1'b1) begin
      n_fail++; $display("FAIL s2_mask_last got %h/%0b exp ffff/1", cur_mask, cur_last);
    end
    take_beats(1, 0);
    check_idle();
    set_row_pat(3); send_row(0, 0);
    check_idle();
    set_row_pat(4); send_row(0, 1);
    wait_valid();
    n_checks++;
    if (cur_eof !== 1'b1) begin n_fail++; $display("FAIL s2_eof got %0b exp 1", cur_eof); end
    take_beats(1, 0);
    set_row_pat(5); send_row(0, 0);
    check_idle();
    sel = 0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] snap [0:K-1][0:SPAN1-1];
    logic [7:0] cap_beat;
    bit stable;
    sel = 0; cfg_pad = 0;
    set_row_rand(); send_row(1, 0);
    set_row_rand(); send_row(0, 0);
    set_row_rand(); send_row(0, 0);
    wait_valid();
    take_beats(1, 0);
    wait_valid();
    cap_beat = cur_beat;
    for (int ky = 0; ky < K; ky++)
      for (int j = 0; j < SPAN1; j++) snap[ky][j] = get_pix(ky, j);
    for (int i = 0; i < 5; i++) begin
      stable = 1;
      for (int ky = 0; ky < K; ky++)
        for (int j = 0; j < SPAN1; j++) if (get_pix(ky, j) !== snap[ky][j]) stable = 0;
      n_checks++;
      if (!stable || cur_valid !== 1'b1 || cur_beat !== cap_beat) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d valid=%0b beat=%0d exp 1/%0d stable=%0b", i, cur_valid, cur_beat, cap_beat, stable);
      end
      n_checks++;
      if (cur_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b exp 0", cur_in_ready); end
      @(negedge clk);
    end
    take_beats(1, 0);
    set_row_rand(); send_row(0, 1);
    take_beats(2, 0);
    check_idle();
  endtask

  task automatic test_reset_emit();
    sel = 0; cfg_pad = 0;
    set_row_rand(); send_row(1, 0);
    set_row_rand(); send_row(0, 0);
    set_row_rand(); send_row(0, 0);
    wait_valid();
    take_beats(1, 0);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== '0 || om1 !== '0) begin
      n_fail++; $display("FAIL rst_emit_out got valid=%0b mask=%h exp 0/0", ov1, om1);
    end
    n_checks++;
    if (ob1 !== 8'd0 || ol1 !== 1'b0 || oe1 !== 1'b0 || ir1 !== 1'b1) begin
      n_fail++; $display("FAIL rst_emit_flags got beat=%0d last=%0b eof=%0b rdy=%0b exp 0/0/0/1", ob1, ol1, oe1, ir1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    fr_cnt = 0; m_closed = 0; m_pad = 0;
    set_row_rand(); send_row(0, 0);
    check_idle();
    set_row_rand(); send_row(0, 0);
    check_idle();
    set_row_rand(); send_row(0, 0);
    wait_valid();
    take_beats(2, 1);
    check_idle();
  endtask

  task automatic test_sof_restart();
    sel = 0; cfg_pad = 0;
    set_row_rand(); send_row(1, 0);
    set_row_rand(); send_row(0, 0);
    check_idle();
    set_row_rand(); send_row(1, 0);
    check_idle();
    set_row_rand(); send_row(0, 0);
    check_idle();
    set_row_rand(); send_row(0, 0);
    wait_valid();
    take_beats(2, 0);
    check_idle();
    set_row_rand(); send_row(0, 1);
    take_beats(2, 1);
    check_idle();
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 14; f++) begin
      sel = 1'($urandom_range(0, 1));
      cfg_pad = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int r = 0; r < len; r++) begin
        set_row_rand();
        send_row(r == 0, r == len - 1);
        cfg_pad = 1'($urandom_range(0, 1));
        take_beats(exp_q.size(), 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        set_row_rand(); send_row(0, 0);
      end
      check_idle();
    end
    sel = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0; hn = 0; fr_cnt = 0; m_closed = 0; m_pad = 0;
    rst_n = 1'b0; sel = 0; cfg_pad = 0; in_valid = 0; in_sof = 0; in_eof = 0;
    out_ready = 0; in_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_pad();
    test_stride2();
    test_backpressure();
    test_reset_emit();
    test_sof_restart();
    test_random();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
